uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver for the board's UART_RXD pin: 8N1 by default, LSB first, fixed baud derived from the system clock.
- Converts the line into parallel bytes with a one-cycle valid strobe, for downstream display and LCD logic in the top level.
- Counterpart of the existing serial transmit path: the same frame format, received instead of sent.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line bit rate in bit/s.
- DATA_BITS, 8: data bits per frame, legal range 5..8.

Ports:
- clk  input  1  system clock (CLOCK_50 in the top level).
- rst  input  1  asynchronous, active-high reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- data  output  DATA_BITS  last correctly received byte.
- valid  output  1  one-cycle pulse: data has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature).
- busy  output  1  high while a frame is in progress.

Behaviour:
- Derived constants:
  - CLKS_PER_BIT = CLK_FREQ/BAUD (integer division); HALF_BIT = CLKS_PER_BIT/2.
  - CLKS_PER_BIT must be >= 4; check this at elaboration.
- Synchronizer: rxd passes through 2 flops to give rx_s; both flops reset to 1. All decisions use rx_s only.
- Reset: state=IDLE, counters 0, data=0, valid=0, frame_err=0, parity_err=0, busy=0. Reset asserted mid-frame aborts the frame with no strobe.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
  - IDLE: when rx_s==0, go to START with the bit counter cleared.
  - START: count HALF_BIT cycles.
    - At the last count, if rx_s==0, go to DATA with bit_idx=0.
    - Otherwise it was a glitch: return to IDLE with no strobe.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first, and increment bit_idx.
    - After bit DATA_BITS-1, go to PARITY if enabled, else STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1 and there is no parity error: load data from the shift register, pulse valid, go to IDLE.
    - If 0: pulse frame_err, leave data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: hold until rx_s==1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Strobes: valid, frame_err and parity_err are registered and high for exactly 1 clk. They are mutually exclusive per frame; frame_err takes priority over parity_err.
- busy = (state != IDLE).
- Latency: valid rises 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT (+CLKS_PER_BIT with parity) cycles after the rxd falling edge, within ±1 cycle.
- Back-to-back frames: returning to IDLE at mid-stop-bit allows a start bit immediately after the stop bit. No idle gap is required.
- data holds its value between frames; it is never cleared except by reset.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the data bits. PARITY state samples it after CLKS_PER_BIT cycles.
  - Mismatch (XOR of data bits and parity bit ≠ 0) is flagged: at STOP, if the stop bit is 1, pulse parity_err instead of valid and leave data unchanged.
- Undefined: no PARITY state, frame is 8N1, parity_err tied to 0.

Test Plan:
- Bench uses CLK_FREQ=160, BAUD=10, so CLKS_PER_BIT=16.
- 1. Send 0xA5 after reset -> data=0xA5, valid high exactly 1 cycle, ~2+8+144 cycles after the start edge; busy=0 afterwards; frame_err=0.
- 2. Send 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses, with data=0x00 then 0xFF; no errors.
- 3. rxd low for 4 cycles, then high -> no valid; busy high briefly, back to 0 within HALF_BIT+3 cycles.
- 4. Send 0x5A correctly, then 0x3C with stop bit 0 held low for 40 cycles -> one frame_err pulse, data stays 0x5A, busy stays high until rxd returns to 1.
- 5. Assert rst during bit 4 of a frame, release, send 0x81 -> no strobe from the aborted frame; data=0x00 after reset, then 0x81 with valid.
- 6. With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> valid, data=0x07. Same byte with parity bit 0 -> parity_err pulse, data unchanged, no valid.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first, 8N1 by default.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bits_check
        $error("uart_rx: DATA_BITS must be in 5..8");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd5,
`endif
        S_WAIT_IDLE = 3'd4
    } state_e;

`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = S_PARITY;

    // Even parity: a set result means the data bits plus parity bit hold an odd count of ones.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] bits, input logic pbit);
        parity_mismatch = (^bits) ^ pbit;
    endfunction
`else
    localparam state_e AFTER_DATA = S_STOP;
`endif

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q;
    logic                   bit_tick;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   perr_q, perr_d;
`endif

    assign rx_s     = rx_sync_q;
    assign bit_tick = (cnt_q == BIT_LAST);

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
                else       state_d = S_IDLE;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) state_d = rx_s ? S_IDLE : S_DATA;
                else                    state_d = S_START;
            end
            S_DATA: begin
                if (bit_tick && (idx_q == IDX_LAST)) state_d = AFTER_DATA;
                else                                 state_d = S_DATA;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) state_d = S_STOP;
                else          state_d = S_PARITY;
            end
`endif
            // Leaving at mid-stop-bit lets a start bit follow the stop bit with no gap.
            S_STOP: begin
                if (bit_tick) state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
                else          state_d = S_STOP;
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_d = S_IDLE;
                else      state_d = S_WAIT_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and strobe next-state logic, decoded from the current state.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            S_START: begin
                if (cnt_q == HALF_LAST) cnt_d = CNT_ZERO;
                else                    cnt_d = cnt_q + CNT_ONE;
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d     = CNT_ZERO;
                    par_bad_d = parity_mismatch(shift_q, rx_s);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            // A low stop bit outranks a parity mismatch, so each frame yields at most one strobe.
            S_STOP: begin
                if (bit_tick) begin
                    cnt_d = CNT_ZERO;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = CNT_ZERO;
            end
            default: begin
                cnt_d = CNT_ZERO;
                idx_d = 3'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= {DATA_BITS{1'b0}};
            data_q  <= {DATA_BITS{1'b0}};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity flag and parity strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16 (CLK_FREQ=160, BAUD=10).
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int HB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LAT = 2 + HB + 9 * CPB + PBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    uart_rx #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int vld_p = 0, vld_h = 0, fe_p = 0, fe_h = 0, pe_p = 0, pe_h = 0;
    int last_vld_cyc = 0, start_cyc = 0;
    logic [7:0] rx_bytes[$];
    logic pv = 1'b0, pf = 1'b0, pp = 1'b0;

    // Strobe monitor: counts pulses and high cycles, logs received bytes.
    always @(negedge clk) begin
        if (valid) begin
            vld_h++;
            if (!pv) begin vld_p++; last_vld_cyc = cyc; rx_bytes.push_back(data); end
        end
        if (frame_err) begin fe_h++; if (!pf) fe_p++; end
        if (parity_err) begin pe_h++; if (!pp) pe_p++; end
        pv = valid; pf = frame_err; pp = parity_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
        start_cyc = cyc;
        rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_v;
        wait_clks(CPB);
`else
        if (par_v === 1'bx) rxd = 1'b1;
`endif
        rxd = stop_v;
        wait_clks(CPB);
    endtask

    int v0, f0, p0, lat;
    logic [7:0] b;

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        wait_clks(3);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        wait_clks(5);

        // 1: single byte 0xA5
        v0 = vld_p;
        b = 8'hA5;
        send_frame(b, 1'b1, ^b);
        wait_clks(2);
        check("t1_valid_cnt", 32'(vld_p - v0), 32'd1);
        check("t1_data", 32'(data), 32'hA5);
        lat = last_vld_cyc - start_cyc;
        if (!((lat >= LAT - 1) && (lat <= LAT + 1)))
            $display("latency observed %0d, window %0d +/- 1", lat, LAT);
        check("t1_latency_in_window", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 32'd1);
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_ferr_cnt", 32'(fe_p), 32'd0);
        check("t1_valid_one_cycle", 32'(vld_h), 32'(vld_p));

        // 2: back-to-back 0x00 then 0xFF
        v0 = vld_p;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_clks(2);
        check("t2_valid_cnt", 32'(vld_p - v0), 32'd2);
        check("t2_first_byte", 32'(rx_bytes[rx_bytes.size() - 2]), 32'h00);
        check("t2_second_byte", 32'(rx_bytes[rx_bytes.size() - 1]), 32'hFF);
        check("t2_ferr_cnt", 32'(fe_p), 32'd0);
        check("t2_perr_cnt", 32'(pe_p), 32'd0);

        // 3: 4-cycle glitch
        wait_clks(10);
        v0 = vld_p;
        rxd = 1'b0;
        wait_clks(4);
        check("t3_busy_during", 32'(busy), 32'h1);
        rxd = 1'b1;
        wait_clks(HB + 3);
        check("t3_busy_cleared", 32'(busy), 32'h0);
        check("t3_no_valid", 32'(vld_p - v0), 32'd0);
        check("t3_no_ferr", 32'(fe_p), 32'd0);
        wait_clks(10);

        // 4: good 0x5A, then 0x3C with stop bit held low
        v0 = vld_p;
        f0 = fe_p;
        p0 = pe_p;
        b = 8'h5A;
        send_frame(b, 1'b1, ^b);
        b = 8'h3C;
        send_frame(b, 1'b0, ^b);
        wait_clks(24);
        check("t4_busy_in_break", 32'(busy), 32'h1);
        check("t4_ferr_cnt", 32'(fe_p - f0), 32'd1);
        rxd = 1'b1;
        wait_clks(5);
        check("t4_busy_after", 32'(busy), 32'h0);
        check("t4_data_kept", 32'(data), 32'h5A);
        check("t4_valid_cnt", 32'(vld_p - v0), 32'd1);
        check("t4_ferr_one_cycle", 32'(fe_h), 32'(fe_p));
        check("t4_no_perr", 32'(pe_p - p0), 32'd0);
        wait_clks(10);

        // 5: reset during bit 4 of 0xC3, then 0x81
        v0 = vld_p;
        f0 = fe_p;
        b = 8'hC3;
        rxd = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            wait_clks(CPB);
        end
        rxd = b[4];
        wait_clks(HB);
        rst = 1'b1;
        rxd = 1'b1;
        wait_clks(2);
        check("t5_data_reset", 32'(data), 32'h0);
        check("t5_busy_reset", 32'(busy), 32'h0);
        rst = 1'b0;
        wait_clks(40);
        check("t5_no_valid", 32'(vld_p - v0), 32'd0);
        check("t5_no_ferr", 32'(fe_p - f0), 32'd0);
        check("t5_data_still_zero", 32'(data), 32'h0);
        b = 8'h81;
        send_frame(b, 1'b1, ^b);
        wait_clks(2);
        check("t5_data_81", 32'(data), 32'h81);
        check("t5_valid_cnt", 32'(vld_p - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
        // 6: parity good then bad on 0x07
        wait_clks(10);
        v0 = vld_p;
        p0 = pe_p;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(2);
        check("t6_good_valid", 32'(vld_p - v0), 32'd1);
        check("t6_good_data", 32'(data), 32'h07);
        check("t6_good_no_perr", 32'(pe_p - p0), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(2);
        check("t6_bad_perr", 32'(pe_p - p0), 32'd1);
        check("t6_bad_no_valid", 32'(vld_p - v0), 32'd1);
        check("t6_bad_data", 32'(data), 32'h07);
        check("t6_perr_one_cycle", 32'(pe_h), 32'(pe_p));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
